// File: rtl/instr_queue.sv
// Instruction queue between fetch and decode: DEPTH-entry FIFO with hold-last-word output,
// flush, sticky overflow and optional empty-queue write-through (INSTR_QUEUE_BYPASS_EN).
module instr_queue #(
    parameter int              WIDTH   = 16,
    parameter int              DEPTH   = 4,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic                         clk,
    input  logic                         rst_b,
    input  logic                         flush,
    input  logic                         wr_en,
    input  logic [WIDTH-1:0]             wr_data,
    output logic                         full,
    input  logic                         rd_en,
    output logic [WIDTH-1:0]             rd_data,
    output logic                         valid,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         ovf
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] hold;
    logic             ovf_q;
    logic             empty, byp, byp_take, pop, store, spop;

    assign empty = (cnt == '0);
    assign full  = (cnt == DEPTH_C);
    assign count = cnt;
    assign ovf   = ovf_q;

`ifdef INSTR_QUEUE_BYPASS_EN
    assign byp = empty & wr_en & ~flush;
`else
    assign byp = 1'b0;
`endif

    always_comb begin
        valid   = ~flush & (~empty | byp);
        rd_data = hold;
        if (!flush) begin
            if (!empty)
                rd_data = mem[rd_ptr];
            else if (byp)
                rd_data = wr_data;
        end
    end

    // A bypassed word consumed in the same cycle goes straight to hold and is never stored.
    assign pop      = rd_en & valid & ~flush;
    assign byp_take = byp & rd_en;
    assign spop     = pop & ~empty;
    assign store    = wr_en & ~full & ~flush & ~byp_take;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            hold   <= RST_VAL;
            ovf_q  <= 1'b0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            ovf_q  <= 1'b0;
        end else begin
            if (store)
                wr_ptr <= wr_ptr + AW'(1);
            if (spop) begin
                rd_ptr <= rd_ptr + AW'(1);
                hold   <= mem[rd_ptr];
            end else if (byp_take) begin
                hold   <= wr_data;
            end
            if (store && !spop)
                cnt <= cnt + CW'(1);
            else if (spop && !store)
                cnt <= cnt - CW'(1);
            if (wr_en && full)
                ovf_q <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            for (int unsigned i = 0; i < DEPTH; i++)
                mem[AW'(i)] <= RST_VAL;
        end else if (store) begin
            mem[wr_ptr] <= wr_data;
        end
    end

endmodule

// File: tb/tb_instr_queue.sv
// Self-checking bench for instr_queue: queue-based reference model compared every cycle,
// plus directed literal checks. Honours INSTR_QUEUE_BYPASS_EN the same way as the design.
module tb_instr_queue;

    localparam int WIDTH = 16;
    localparam int DEPTH = 4;
`ifdef INSTR_QUEUE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             clk_en = 1'b0;
    logic             rst_b = 1'b0;
    logic             flush = 1'b0;
    logic             wr_en = 1'b0;
    logic [WIDTH-1:0] wr_data = '0;
    logic             rd_en = 1'b0;
    logic             full;
    logic [WIDTH-1:0] rd_data;
    logic             valid;
    logic [2:0]       count;
    logic             ovf;

    int checks = 0;
    int errors = 0;

    instr_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RST_VAL(16'h0000)) dut (
        .clk(clk), .rst_b(rst_b), .flush(flush), .wr_en(wr_en), .wr_data(wr_data),
        .full(full), .rd_en(rd_en), .rd_data(rd_data), .valid(valid),
        .count(count), .ovf(ovf)
    );

    initial begin
        wait (clk_en);
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a plain FIFO of words plus the last consumed word.
    logic [WIDTH-1:0] q[$];
    logic [WIDTH-1:0] m_hold = '0;
    bit               m_ovf = 1'b0;
    int               m_sz;
    bit               m_took;

    always @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            q.delete();
            m_hold = '0;
            m_ovf  = 1'b0;
        end else if (flush) begin
            q.delete();
            m_ovf = 1'b0;
        end else begin
            m_sz   = q.size();
            m_took = 1'b0;
            if (rd_en && (m_sz > 0 || (BYP && wr_en))) begin
                if (m_sz > 0) m_hold = q.pop_front();
                else begin
                    m_hold = wr_data;
                    m_took = 1'b1;
                end
            end
            if (wr_en) begin
                if (m_sz == DEPTH) m_ovf = 1'b1;
                else if (!m_took) q.push_back(wr_data);
            end
        end
    end

    logic             e_valid;
    logic [WIDTH-1:0] e_data;

    always @(negedge clk) begin
        if (!rst_b || flush) begin
            e_valid = 1'b0;
            e_data  = m_hold;
        end else if (q.size() > 0) begin
            e_valid = 1'b1;
            e_data  = q[0];
        end else if (BYP && wr_en) begin
            e_valid = 1'b1;
            e_data  = wr_data;
        end else begin
            e_valid = 1'b0;
            e_data  = m_hold;
        end
        chk("model_valid", 32'(valid), 32'(e_valid));
        chk("model_rd_data", 32'(rd_data), 32'(e_data));
        chk("model_count", 32'(count), 32'(q.size()));
        chk("model_full", 32'(full), 32'(q.size() == DEPTH));
        chk("model_ovf", 32'(ovf), 32'(m_ovf));
    end

    task automatic set(input logic f, input logic w, input logic [WIDTH-1:0] wd, input logic r);
        flush = f; wr_en = w; wr_data = wd; rd_en = r;
    endtask

    task automatic idle();
        set(1'b0, 1'b0, '0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic mid();
        @(negedge clk); #1;
    endtask

    initial begin
        // Reset with the clock idle
        #3;
        chk("rst_valid", 32'(valid), 32'h0);
        chk("rst_rd_data", 32'(rd_data), 32'h0);
        chk("rst_count", 32'(count), 32'h0);
        chk("rst_full", 32'(full), 32'h0);
        chk("rst_ovf", 32'(ovf), 32'h0);
        #10 rst_b = 1'b1;
        #2 clk_en = 1'b1;
        tick();

        // Push into empty queue without reading
        set(1'b0, 1'b1, 16'hA5A5, 1'b0);
        mid();
        chk("push_empty_valid", 32'(valid), BYP ? 32'h1 : 32'h0);
        chk("push_empty_data", 32'(rd_data), BYP ? 32'hA5A5 : 32'h0);
        tick();
        chk("push_empty_count", 32'(count), 32'h1);
        set(1'b0, 1'b0, '0, 1'b1);
        tick(); idle(); #1;
        chk("pop_a5_valid", 32'(valid), 32'h0);
        chk("pop_a5_hold", 32'(rd_data), 32'hA5A5);

        // Simultaneous push and pop into an empty queue
        set(1'b0, 1'b1, 16'h1234, 1'b1);
        mid();
        chk("wt_valid", 32'(valid), BYP ? 32'h1 : 32'h0);
        chk("wt_data", 32'(rd_data), BYP ? 32'h1234 : 32'hA5A5);
        tick(); idle(); #1;
        chk("wt_count", 32'(count), BYP ? 32'h0 : 32'h1);
        chk("wt_valid_after", 32'(valid), BYP ? 32'h0 : 32'h1);
        chk("wt_data_after", 32'(rd_data), 32'h1234);
        set(1'b0, 1'b0, '0, 1'b1);
        tick(); idle(); #1;
        chk("wt_drained_count", 32'(count), 32'h0);
        chk("wt_drained_data", 32'(rd_data), 32'h1234);

        // Fill, overflow, drain in order
        for (int k = 1; k <= 4; k++) begin
            set(1'b0, 1'b1, 16'(k), 1'b0);
            tick();
        end
        idle(); #1;
        chk("fill_full", 32'(full), 32'h1);
        chk("fill_count", 32'(count), 32'h4);
        set(1'b0, 1'b1, 16'h0005, 1'b0);
        tick(); idle(); #1;
        chk("ovf_set", 32'(ovf), 32'h1);
        chk("ovf_count", 32'(count), 32'h4);
        for (int k = 1; k <= 4; k++) begin
            set(1'b0, 1'b0, '0, 1'b1);
            mid();
            chk("drain_order", 32'(rd_data), 32'(k));
            tick();
        end
        idle(); #1;
        chk("drain_valid", 32'(valid), 32'h0);
        chk("drain_hold", 32'(rd_data), 32'h0004);

        // Flush with push and pop asserted
        for (int k = 1; k <= 3; k++) begin
            set(1'b0, 1'b1, 16'(k * 16'h11), 1'b0);
            tick();
        end
        idle(); #1;
        chk("preflush_count", 32'(count), 32'h3);
        chk("preflush_ovf", 32'(ovf), 32'h1);
        set(1'b1, 1'b1, 16'h0099, 1'b1);
        mid();
        chk("flush_cyc_valid", 32'(valid), 32'h0);
        chk("flush_cyc_data", 32'(rd_data), 32'h0004);
        tick(); idle(); #1;
        chk("flush_count", 32'(count), 32'h0);
        chk("flush_ovf", 32'(ovf), 32'h0);
        chk("flush_valid", 32'(valid), 32'h0);
        chk("flush_hold", 32'(rd_data), 32'h0004);

        // Steady push/pop across pointer wrap
        set(1'b0, 1'b1, 16'h0100, 1'b0); tick();
        set(1'b0, 1'b1, 16'h0101, 1'b0); tick();
        for (int i = 2; i < 12; i++) begin
            set(1'b0, 1'b1, 16'(16'h0100 + i), 1'b1);
            mid();
            chk("wrap_order", 32'(rd_data), 32'(16'h0100 + i - 2));
            tick();
            chk("wrap_count", 32'(count), 32'h2);
        end
        set(1'b0, 1'b0, '0, 1'b1); tick(); tick(); idle(); #1;
        chk("wrap_hold", 32'(rd_data), 32'h010B);

        // Latency of a push into an empty queue
        set(1'b0, 1'b1, 16'hBEEF, 1'b0);
        mid();
        chk("beef_push_valid", 32'(valid), BYP ? 32'h1 : 32'h0);
        tick(); idle(); #1;
        chk("beef_next_valid", 32'(valid), 32'h1);
        chk("beef_next_data", 32'(rd_data), 32'hBEEF);
        set(1'b0, 1'b0, '0, 1'b1); tick(); idle(); #1;

        // Full queue with push and pop together: pop wins, push dropped
        for (int k = 1; k <= 4; k++) begin
            set(1'b0, 1'b1, 16'(16'h0040 + k), 1'b0);
            tick();
        end
        set(1'b0, 1'b1, 16'h0077, 1'b1);
        mid();
        chk("fullpp_head", 32'(rd_data), 32'h0041);
        tick(); idle(); #1;
        chk("fullpp_count", 32'(count), 32'h3);
        chk("fullpp_full", 32'(full), 32'h0);
        chk("fullpp_ovf", 32'(ovf), 32'h1);
        chk("fullpp_head2", 32'(rd_data), 32'h0042);

        // Asynchronous reset between clock edges
        #2 rst_b = 1'b0;
        #1;
        chk("async_count", 32'(count), 32'h0);
        chk("async_ovf", 32'(ovf), 32'h0);
        chk("async_valid", 32'(valid), 32'h0);
        chk("async_data", 32'(rd_data), 32'h0);
        @(posedge clk); #1 rst_b = 1'b1;
        tick();
        chk("post_rst_count", 32'(count), 32'h0);

        // Mixed traffic, checked by the model every cycle
        for (int n = 0; n < 300; n++) begin
            set($urandom_range(0, 15) == 0, $urandom_range(0, 2) != 0,
                16'($urandom), $urandom_range(0, 2) == 0 || n > 200);
            tick();
        end
        idle(); tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
